// File: rtl/watchdog_pkg.sv
// Shared definitions for the watchdog petter: controller states, count width
// and the nanoseconds-per-clock helper.
package watchdog_pkg;

  localparam int unsigned COUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PET   = 2'd2,
    FAULT = 2'd3
  } state_e;

  // Whole nanoseconds that elapse per clock period at the given frequency.
  function automatic logic [31:0] nsPerClk(input logic [31:0] clkHz);
    return 32'd1000000000 / clkHz;
  endfunction

endpackage

// File: rtl/pet_interval_timer.sv
// Measures half of the watchdog window in nanoseconds, one clock period at a
// time. The threshold follows the live window value every cycle, so a window
// shrink mid-interval takes effect on the very next compare.
module pet_interval_timer
  import watchdog_pkg::*;
#(
  parameter logic [31:0] CLK_HZ = 32'd50000000
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        run,
  input  logic        clear,
  input  logic [31:0] time_ns,
  output logic        expire
);

  localparam logic [31:0] NS_PER_CLK = nsPerClk(CLK_HZ);

  logic [32:0] acc_q;
  logic [32:0] acc_d;
  logic [32:0] accNext;
  logic [31:0] halfWindow;
  logic [31:0] threshold;

  // Clamp the half window to at least one clock period, compare and step the accumulator.
  always_comb begin
    halfWindow = time_ns >> 1;
    threshold  = (halfWindow > NS_PER_CLK) ? halfWindow : NS_PER_CLK;
    accNext    = acc_q + {1'b0, NS_PER_CLK};
    expire     = run && (accNext >= {1'b0, threshold});
    acc_d      = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (run) begin
      acc_d = expire ? '0 : accNext;
    end
  end

  // Accumulator register; holds its value whenever the timer is neither running nor cleared.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/watchdog_petter.sv
// Keeps an external watchdog serviced with single-cycle pet pulses at half its
// window while software reports alive, and counts watchdog barks, latching a
// fault once the configured number of barks has been seen.
module watchdog_petter
  import watchdog_pkg::*;
#(
  parameter logic [31:0] CLK_HZ    = 32'd50000000,
  parameter logic [7:0]  MAX_WOOFS = 8'd3
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic [31:0]        time_ns,
  input  logic               enable,
  input  logic               alive,
  input  logic               woof,
  output logic               pet,
  output logic [COUNT_W-1:0] woof_count,
  output logic               fault
);

  state_e             state_q;
  state_e             state_d;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic               woofDly_q;
  logic               pet_q;
  logic               fault_q;
  logic               woofRise;
  logic               woofHit;
  logic               timerRun;
  logic               timerClear;
  logic               timerExpire;

  assign timerRun   = enable && (state_q == ARMED);
  assign timerClear = !enable || (state_q == IDLE);
  assign woofRise   = woof && !woofDly_q;

  pet_interval_timer #(
    .CLK_HZ (CLK_HZ)
  ) u_timer (
    .clk     (clk),
    .nRst    (nRst),
    .run     (timerRun),
    .clear   (timerClear),
    .time_ns (time_ns),
    .expire  (timerExpire)
  );

  // Next state and bark count; a bark that reaches the limit outranks a pending pet, and enable low overrides everything.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    woofHit = 1'b0;
    if ((state_q != IDLE) && woofRise && (count_q != {COUNT_W{1'b1}})) begin
      count_d = count_q + 8'd1;
      woofHit = (count_d == MAX_WOOFS);
    end
    unique case (state_q)
      IDLE: begin
        state_d = ARMED;
      end
      ARMED: begin
        if (woofHit) begin
          state_d = FAULT;
        end else if (timerExpire && alive) begin
          state_d = PET;
        end
      end
      PET: begin
        state_d = woofHit ? FAULT : ARMED;
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!enable) begin
      state_d = IDLE;
      count_d = '0;
    end
  end

  // State, bark history and registered outputs, all decoded from the upcoming state.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      woofDly_q <= 1'b0;
      pet_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      woofDly_q <= woof;
      pet_q     <= (state_d == PET);
      fault_q   <= (state_d == FAULT);
    end
  end

  assign pet        = pet_q;
  assign woof_count = count_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_watchdog_petter.sv
// Self-checking bench for watchdog_petter: a fixed vector table with a small
// window, hand sequences for the multi-cycle timing corners, then randomized
// traffic compared against an interval-counting reference model.
module tb_watchdog_petter;

  localparam int NS        = 20;
  localparam int MAX_WOOFS = 3;

  typedef struct {
    logic        en;
    logic        al;
    logic        wf;
    logic [31:0] t;
    logic        expPet;
    logic [7:0]  expCnt;
    logic        expFault;
  } vec_t;

  logic        clk;
  logic        nRst;
  logic [31:0] time_ns;
  logic        enable;
  logic        alive;
  logic        woof;
  logic        pet;
  logic [7:0]  woof_count;
  logic        fault;

  int checks;
  int passes;
  int fails;

  vec_t vecQ[$];

  // Reference model: cycles elapsed in the current interval and barks seen.
  bit mRun;
  bit mPetNow;
  bit mFault;
  bit mPrevWoof;
  int mElapsed;
  int mWoofs;

  watchdog_petter #(
    .CLK_HZ    (32'd50000000),
    .MAX_WOOFS (8'd3)
  ) dut (
    .clk        (clk),
    .nRst       (nRst),
    .time_ns    (time_ns),
    .enable     (enable),
    .alive      (alive),
    .woof       (woof),
    .pet        (pet),
    .woof_count (woof_count),
    .fault      (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One model step per clock, computed from the interval rules in whole clock periods.
  task automatic modelStep();
    bit     rise;
    bit     hit;
    longint thr;
    rise      = woof && !mPrevWoof;
    mPrevWoof = woof;
    if (!enable) begin
      mRun = 0; mPetNow = 0; mFault = 0; mElapsed = 0; mWoofs = 0;
      return;
    end
    if (!mRun) begin
      mRun = 1; mElapsed = 0;
      return;
    end
    hit = 0;
    if (rise && mWoofs < 255) begin
      mWoofs++;
      hit = (mWoofs == MAX_WOOFS);
    end
    if (mFault) return;
    if (hit) begin
      mFault = 1; mPetNow = 0;
      return;
    end
    if (mPetNow) begin
      mPetNow = 0; mElapsed = 0;
      return;
    end
    thr = longint'(time_ns) / 2;
    if (thr < NS) thr = NS;
    if (longint'(mElapsed + 1) * NS >= thr) begin
      mElapsed = 0;
      mPetNow  = alive;
    end else begin
      mElapsed++;
    end
  endtask

  // Advance the model alongside the DUT, clearing it on the same asynchronous reset.
  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      mRun = 0; mPetNow = 0; mFault = 0; mPrevWoof = 0; mElapsed = 0; mWoofs = 0;
    end else begin
      modelStep();
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic en, input logic al, input logic wf, input logic [31:0] t);
    enable  = en;
    alive   = al;
    woof    = wf;
    time_ns = t;
  endtask

  task automatic checkOutput(input string name, input logic expPet, input logic [7:0] expCnt, input logic expFault);
    checks++;
    if (pet !== expPet || woof_count !== expCnt || fault !== expFault) begin
      fails++;
      $display("[TB] FAIL %s: got pet=%b count=%0d fault=%b, expected pet=%b count=%0d fault=%b",
               name, pet, woof_count, fault, expPet, expCnt, expFault);
    end else begin
      passes++;
    end
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end else begin
      passes++;
    end
  endtask

  // Ticks until pet is seen high; n is the number of ticks taken, or -1 on timeout.
  task automatic waitPet(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (pet === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic countPets(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (pet === 1'b1) n++;
    end
  endtask

  task automatic addVec(input logic en, input logic al, input logic wf, input logic [31:0] t,
                        input logic p, input logic [7:0] c, input logic f);
    vec_t v;
    v.en = en; v.al = al; v.wf = wf; v.t = t;
    v.expPet = p; v.expCnt = c; v.expFault = f;
    vecQ.push_back(v);
  endtask

  // Three separate barks, each held high for five cycles, tracking the count as it steps.
  task automatic woofPulses();
    for (int p = 0; p < 3; p++) begin
      woof = 1'b1;
      tick();
      checkValue($sformatf("woofCount%0d", p + 1), woof_count, p + 1);
      checkValue($sformatf("woofFault%0d", p + 1), fault, (p == 2) ? 1 : 0);
      for (int i = 0; i < 4; i++) tick();
      woof = 1'b0;
      for (int i = 0; i < 5; i++) tick();
    end
  endtask

  initial begin
    int n;
    int k;
    checks = 0;
    passes = 0;
    fails  = 0;

    // Window time_ns = 0 gives an ARMED/PET alternation, so every row is one cycle.
    addVec(0, 1, 0, 0, 0, 0, 0);
    addVec(1, 1, 0, 0, 0, 0, 0);
    addVec(1, 1, 0, 0, 1, 0, 0);
    addVec(1, 1, 0, 0, 0, 0, 0);
    addVec(1, 1, 0, 0, 1, 0, 0);
    addVec(1, 1, 1, 0, 0, 1, 0);
    addVec(1, 1, 0, 0, 1, 1, 0);
    addVec(1, 1, 1, 0, 0, 2, 0);
    addVec(1, 1, 0, 0, 1, 2, 0);
    addVec(1, 1, 1, 0, 0, 3, 1);
    addVec(1, 1, 0, 0, 0, 3, 1);
    addVec(1, 1, 1, 0, 0, 4, 1);
    addVec(0, 1, 1, 0, 0, 0, 0);
    addVec(0, 1, 1, 0, 0, 0, 0);
    addVec(1, 1, 1, 0, 0, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, 0, 0, 1, 0, 0);
    addVec(1, 1, 1, 0, 0, 1, 0);
    addVec(1, 1, 0, 0, 1, 1, 0);
    addVec(1, 1, 1, 0, 0, 2, 0);
    addVec(1, 1, 0, 0, 1, 2, 0);
    addVec(1, 1, 0, 0, 0, 2, 0);
    addVec(1, 1, 1, 0, 0, 3, 1);

    nRst = 1'b0;
    applyStimulus(0, 0, 0, 32'd1000);
    #1;
    checkOutput("resetState", 0, 0, 0);
    tick();
    tick();
    nRst = 1'b1;

    $display("[TB] idle hold with enable low");
    countPets(100, n);
    checkValue("idlePets", n, 0);
    checkOutput("idleState", 0, 0, 0);

    $display("[TB] vector table");
    for (int i = 0; i < vecQ.size(); i++) begin
      applyStimulus(vecQ[i].en, vecQ[i].al, vecQ[i].wf, vecQ[i].t);
      tick();
      checkOutput($sformatf("vec%0d", i), vecQ[i].expPet, vecQ[i].expCnt, vecQ[i].expFault);
    end

    $display("[TB] pet cadence with 1000 ns window");
    applyStimulus(0, 1, 0, 32'd1000);
    tick();
    checkOutput("clearBeforeCadence", 0, 0, 0);
    applyStimulus(1, 1, 0, 32'd1000);
    waitPet(200, n);
    checkValue("firstPetLatency", n, 26);
    waitPet(200, n);
    checkValue("petSpacing1", n, 26);
    tick();
    checkValue("petWidth", pet, 0);
    waitPet(200, n);
    checkValue("petSpacing2", n, 25);

    $display("[TB] withheld pets while alive is low");
    alive = 1'b0;
    countPets(60, n);
    checkValue("withheldPets", n, 0);
    alive = 1'b1;
    // Expiries land 26, 51 and 76 cycles after the last pet; only the 76th sees alive high.
    waitPet(200, n);
    checkValue("petAfterAlive", n, 16);

    $display("[TB] window shrink mid-interval");
    countPets(21, n);
    checkValue("petsBeforeShrink", n, 0);
    time_ns = 32'd100;
    tick();
    checkValue("petAfterShrink", pet, 1);
    waitPet(50, n);
    checkValue("shrunkSpacing", n, 4);

    $display("[TB] reset during a pet pulse");
    nRst = 1'b0;
    #1;
    checkOutput("resetMidPet", 0, 0, 0);
    @(negedge clk);
    applyStimulus(1, 1, 0, 32'd1000);
    nRst = 1'b1;
    waitPet(200, n);
    checkValue("petAfterReset", n, 26);

    $display("[TB] bark counting to fault");
    tick();
    woofPulses();
    countPets(60, n);
    checkValue("petsInFault", n, 0);
    checkOutput("faultHeld", 0, 3, 1);
    enable = 1'b0;
    tick();
    checkOutput("faultCleared", 0, 0, 0);
    enable = 1'b1;
    tick();
    woofPulses();
    nRst = 1'b0;
    #1;
    checkOutput("resetMidFault", 0, 0, 0);
    @(negedge clk);
    nRst = 1'b1;
    tick();
    checkOutput("afterFaultReset", 0, 0, 0);

    $display("[TB] randomized traffic against the reference model");
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] windows [8];
      windows = '{32'd0, 32'd10, 32'd40, 32'd41, 32'd60, 32'd100, 32'd200, 32'd1000};
      enable = ($urandom_range(0, 99) < 97);
      alive  = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 7) == 0) woof = ~woof;
      if ($urandom_range(0, 39) == 0) begin
        k       = $urandom_range(0, 7);
        time_ns = windows[k];
      end
      tick();
      checkOutput($sformatf("rand%0d", i), mPetNow, 8'(mWoofs), mFault);
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
